ifetch_bytes: RTL and testbench
===============================

IFETCH_BYTES -- requirements
Module: ifetch_bytes

Interface
REQ-001 SHALL have parameter DATA, default 8: memory byte width in bits.
REQ-002 SHALL have parameter ADDR, default 16: memory address width in bits.
REQ-003 SHALL have parameter NBYTES, default 2: bytes per instruction, range 1..4.
REQ-004 SHALL have parameter RESET_PC, default 0: fetch address after reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port mem_addr, output, ADDR bits: read address to the RAM read port.
REQ-008 SHALL have port mem_dout, input, DATA bits: RAM read data, valid one cycle after the address.
REQ-009 SHALL have port redir_valid, input, 1 bit: branch/jump redirect request.
REQ-010 SHALL have port redir_pc, input, ADDR bits: redirect target.
REQ-011 SHALL have port ins_valid, output, 1 bit: an instruction is presented.
REQ-012 SHALL have port ins_ready, input, 1 bit: downstream accepts the instruction.
REQ-013 SHALL have port ins_data, output, DATA*NBYTES bits: the assembled instruction.
REQ-014 SHALL have port ins_pc, output, ADDR bits: address of the instruction's first byte.
REQ-015 SHALL have port halted, output, 1 bit: fetch stopped on a halt word.

Function
REQ-016 SHALL have FSM states FETCH (issuing/capturing bytes), HOLD (presenting the instruction) and HALT.
REQ-017 In FETCH, SHALL drive mem_addr = pc + i, issuing one byte per cycle for i = 0..NBYTES-1; mem_addr in other states is don't-care.
REQ-018 SHALL capture mem_dout one cycle after each issue; byte 0 goes to the MSB of ins_data (big-endian).
REQ-019 SHALL compute addresses modulo 2**ADDR, so 0xFFFF + 1 wraps to 0x0000.
REQ-020 SHALL raise ins_valid in the cycle after the last byte is captured, i.e. NBYTES+1 cycles after FETCH begins, and enter HOLD.
REQ-021 In HOLD, SHALL keep ins_valid, ins_data and ins_pc stable until ins_valid && ins_ready.
REQ-022 On the handshake, SHALL set pc = pc + NBYTES, drop ins_valid the next cycle and re-enter FETCH at byte 0.
REQ-023 When redir_valid = 1 in any state, SHALL set pc = redir_pc, discard captured and in-flight bytes, clear ins_valid and halted the next cycle, and enter FETCH at byte 0.
REQ-024 When redir_valid coincides with a handshake, the instruction SHALL count as consumed and the redirect target SHALL win over pc + NBYTES.
REQ-025 SHALL never assert ins_valid while assembly is partial.

Reset
REQ-026 While rst = 1, SHALL set pc = RESET_PC, state = FETCH, byte counters = 0, ins_valid = 0, ins_data = 0, ins_pc = RESET_PC and halted = 0.
REQ-027 rst SHALL override redir_valid and ins_ready.
REQ-028 Reset in mid-assembly SHALL discard all partial bytes.
REQ-029 Fetch SHALL start at RESET_PC in the first cycle after rst deasserts.

Configuration
REQ-030 With macro IFETCH_HALT_EN defined, an assembled word of all ones SHALL NOT be presented; instead the block SHALL enter HALT with halted = 1 and ins_valid = 0, and leave HALT only on redirect or reset.
REQ-031 Without IFETCH_HALT_EN, the all-ones word SHALL be presented as a normal instruction, HALT SHALL be unreachable and halted SHALL be tied to 0.

Verification
REQ-032 Reset-then-release, NBYTES=2, memory 0x0000=0x12 and 0x0001=0x34 -> mem_addr reads 0x0000 then 0x0001; ins_valid=1 on cycle 3 with ins_data=0x1234 and ins_pc=0x0000.
REQ-033 Hold ins_ready=0 for 5 cycles -> ins_valid, ins_data and ins_pc stay unchanged; on ins_ready=1 the next fetch starts at 0x0002.
REQ-034 Assert redir_valid with redir_pc=0x0100 after byte 0 has been captured -> the partial instruction is dropped; the next ins_pc=0x0100 with data from 0x0100/0x0101.
REQ-035 Set pc=0xFFFF via redirect -> mem_addr sequence is 0xFFFF, 0x0000; ins_pc=0xFFFF.
REQ-036 With IFETCH_HALT_EN, memory 0x0010=0xFF and 0x0011=0xFF -> halted=1 and ins_valid stays 0; a redirect to 0x0000 clears halted and fetch resumes. Without the macro, ins_data=0xFFFF is presented.
REQ-037 Assert rst during HOLD -> ins_valid=0 on the next cycle, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_bytes.sv
// ifetch_bytes: instruction fetch unit that assembles multi-byte instructions
// from a byte-wide synchronous RAM read port (read data valid one cycle after
// the address). Bytes are assembled big-endian: the byte at pc goes to the MSB.
//
// Parameters:
//   DATA     - memory byte width in bits
//   ADDR     - memory address width in bits (addresses wrap modulo 2**ADDR)
//   NBYTES   - bytes per instruction (1..4)
//   RESET_PC - fetch address after reset
//
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   mem_addr    - RAM read address
//   mem_dout    - RAM read data (one cycle after mem_addr)
//   redir_valid - redirect request, wins over everything except rst
//   redir_pc    - redirect target
//   ins_valid   - assembled instruction presented
//   ins_ready   - downstream accepts the instruction
//   ins_data    - assembled instruction, byte 0 in the MSBs
//   ins_pc      - address of the instruction's first byte
//   halted      - fetch stopped on an all-ones word
//
// Optional feature: define IFETCH_HALT_EN to stop on an all-ones word instead
// of presenting it. Without the macro, halted is tied low.

module ifetch_bytes #(
    parameter int DATA     = 8,
    parameter int ADDR     = 16,
    parameter int NBYTES   = 2,
    parameter int RESET_PC = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR-1:0]        mem_addr,
    input  logic [DATA-1:0]        mem_dout,
    input  logic                   redir_valid,
    input  logic [ADDR-1:0]        redir_pc,
    output logic                   ins_valid,
    input  logic                   ins_ready,
    output logic [DATA*NBYTES-1:0] ins_data,
    output logic [ADDR-1:0]        ins_pc,
    output logic                   halted
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam int IW = DATA * NBYTES;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ADDR-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [IW-1:0]   data_q, data_d;
    logic [ADDR-1:0] ipc_q, ipc_d;
    logic [IW-1:0]   assembled;

`ifdef IFETCH_HALT_EN
    logic            halted_q, halted_d;
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    // cnt runs 0..NBYTES in FETCH: cnt issues address pc+cnt while the byte
    // issued at cnt-1 is captured, so FETCH lasts NBYTES+1 cycles.
    assign mem_addr  = pc_q + ADDR'(cnt_q);
    assign ins_valid = valid_q;
    assign ins_data  = data_q;
    assign ins_pc    = ipc_q;

    // Shift-in works for any NBYTES, including 1 where the shift empties it.
    always_comb begin
        assembled           = data_q << DATA;
        assembled[DATA-1:0] = mem_dout;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        data_d   = data_q;
        ipc_d    = ipc_q;
`ifdef IFETCH_HALT_EN
        halted_d = halted_q;
`endif

        case (state_q)
            FETCH: begin
                if (cnt_q != '0) begin
                    data_d = assembled;
                end
                if (cnt_q == CW'(NBYTES)) begin
                    cnt_d = '0;
                    ipc_d = pc_q;
`ifdef IFETCH_HALT_EN
                    if (assembled == '1) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end
`else
                    state_d = HOLD;
                    valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (ins_ready) begin
                    pc_d    = pc_q + ADDR'(NBYTES);
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
                cnt_d   = '0;
            end
        endcase

        // Redirect overrides the handshake result and any partial assembly.
        if (redir_valid) begin
            pc_d     = redir_pc;
            cnt_d    = '0;
            valid_d  = 1'b0;
            state_d  = FETCH;
`ifdef IFETCH_HALT_EN
            halted_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            cnt_q    <= '0;
            pc_q     <= ADDR'(RESET_PC);
            valid_q  <= 1'b0;
            data_q   <= '0;
            ipc_q    <= ADDR'(RESET_PC);
`ifdef IFETCH_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ipc_q    <= ipc_d;
`ifdef IFETCH_HALT_EN
            halted_q <= halted_d;
`endif
        end
    end

endmodule

// File: tb/tb_ifetch_bytes.sv
// Directed testbench for ifetch_bytes (default parameters, NBYTES=2).
// A byte RAM model with one-cycle read latency feeds the fetch unit.

module tb_ifetch_bytes;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins_data;
    logic [15:0] ins_pc;
    logic        halted;

    int vecs = 0;
    int errs = 0;

    logic [7:0] mem [0:65535];

    ifetch_bytes #(
        .DATA(8),
        .ADDR(16),
        .NBYTES(2),
        .RESET_PC(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_addr(mem_addr),
        .mem_dout(mem_dout),
        .redir_valid(redir_valid),
        .redir_pc(redir_pc),
        .ins_valid(ins_valid),
        .ins_ready(ins_ready),
        .ins_data(ins_data),
        .ins_pc(ins_pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_dout <= mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h12;
        mem[16'h0001] = 8'h34;
        mem[16'h0002] = 8'h56;
        mem[16'h0003] = 8'h78;
        mem[16'h0004] = 8'hEE;
        mem[16'h0005] = 8'hDD;
        mem[16'h0100] = 8'hAB;
        mem[16'h0101] = 8'hCD;
        mem[16'hFFFF] = 8'h9A;
        mem[16'h0010] = 8'hFF;
        mem[16'h0011] = 8'hFF;

        rst = 1'b1; ins_ready = 1'b0; redir_valid = 1'b0; redir_pc = 16'h0000;
        tick(); tick();
        check("rst_valid", 32'(ins_valid), 32'h0);
        check("rst_data",  32'(ins_data),  32'h0);
        check("rst_pc",    32'(ins_pc),    32'h0);
        check("rst_halted", 32'(halted),   32'h0);

        // First fetch after release
        rst = 1'b0;
        check("f0_addr0", 32'(mem_addr), 32'h0000);
        tick();
        check("f0_addr1", 32'(mem_addr), 32'h0001);
        check("f0_nvalid1", 32'(ins_valid), 32'h0);
        tick();
        check("f0_nvalid2", 32'(ins_valid), 32'h0);
        tick();
        check("f0_valid", 32'(ins_valid), 32'h1);
        check("f0_data",  32'(ins_data),  32'h1234);
        check("f0_pc",    32'(ins_pc),    32'h0000);

        // Back-pressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 32'(ins_valid), 32'h1);
            check("hold_data",  32'(ins_data),  32'h1234);
            check("hold_pc",    32'(ins_pc),    32'h0000);
        end
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        check("acc_nvalid", 32'(ins_valid), 32'h0);
        check("acc_addr0",  32'(mem_addr),  32'h0002);
        tick();
        check("acc_addr1",  32'(mem_addr),  32'h0003);
        tick(); tick();
        check("f1_valid", 32'(ins_valid), 32'h1);
        check("f1_data",  32'(ins_data),  32'h5678);
        check("f1_pc",    32'(ins_pc),    32'h0002);

        // Accept, then redirect after byte 0 of the next word is captured
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        check("f2_addr0", 32'(mem_addr), 32'h0004);
        tick(); tick();
        redir_valid = 1'b1; redir_pc = 16'h0100;
        tick();
        redir_valid = 1'b0;
        check("rd_nvalid", 32'(ins_valid), 32'h0);
        check("rd_addr0",  32'(mem_addr),  32'h0100);
        tick();
        check("rd_addr1",  32'(mem_addr),  32'h0101);
        check("rd_nvalid1", 32'(ins_valid), 32'h0);
        tick(); tick();
        check("rd_valid", 32'(ins_valid), 32'h1);
        check("rd_data",  32'(ins_data),  32'hABCD);
        check("rd_pc",    32'(ins_pc),    32'h0100);

        // Redirect coinciding with handshake: target wins over pc+2
        ins_ready = 1'b1; redir_valid = 1'b1; redir_pc = 16'hFFFF;
        tick();
        ins_ready = 1'b0; redir_valid = 1'b0;
        check("wr_nvalid", 32'(ins_valid), 32'h0);
        check("wr_addr0",  32'(mem_addr),  32'hFFFF);
        tick();
        check("wr_addr1",  32'(mem_addr),  32'h0000);
        tick(); tick();
        check("wr_valid", 32'(ins_valid), 32'h1);
        check("wr_data",  32'(ins_data),  32'h9A12);
        check("wr_pc",    32'(ins_pc),    32'hFFFF);

        // All-ones word at 0x0010
        ins_ready = 1'b1; redir_valid = 1'b1; redir_pc = 16'h0010;
        tick();
        ins_ready = 1'b0; redir_valid = 1'b0;
        tick(); tick(); tick();
`ifdef IFETCH_HALT_EN
        check("ht_halted", 32'(halted),    32'h1);
        check("ht_nvalid", 32'(ins_valid), 32'h0);
        tick(); tick();
        check("ht_stay",    32'(halted),    32'h1);
        check("ht_nvalid2", 32'(ins_valid), 32'h0);
`else
        check("ff_valid",  32'(ins_valid), 32'h1);
        check("ff_data",   32'(ins_data),  32'hFFFF);
        check("ff_pc",     32'(ins_pc),    32'h0010);
        check("ff_halted", 32'(halted),    32'h0);
`endif
        redir_valid = 1'b1; redir_pc = 16'h0000;
        tick();
        redir_valid = 1'b0;
        check("rs_halted", 32'(halted),    32'h0);
        check("rs_nvalid", 32'(ins_valid), 32'h0);
        check("rs_addr0",  32'(mem_addr),  32'h0000);
        tick(); tick(); tick();
        check("rs_valid", 32'(ins_valid), 32'h1);
        check("rs_data",  32'(ins_data),  32'h1234);

        // Reset during HOLD overrides ready and redirect
        rst = 1'b1; ins_ready = 1'b1; redir_valid = 1'b1; redir_pc = 16'h0100;
        tick();
        rst = 1'b0; ins_ready = 1'b0; redir_valid = 1'b0;
        check("rh_nvalid", 32'(ins_valid), 32'h0);
        check("rh_data",   32'(ins_data),  32'h0);
        check("rh_addr0",  32'(mem_addr),  32'h0000);
        tick();
        check("rh_addr1",  32'(mem_addr),  32'h0001);
        tick(); tick();
        check("rh_valid", 32'(ins_valid), 32'h1);
        check("rh_data2", 32'(ins_data),  32'h1234);
        check("rh_pc",    32'(ins_pc),    32'h0000);

        // Reset mid-assembly discards the partial word
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_addr0", 32'(mem_addr), 32'h0000);
        tick(); tick();
        check("rm_nvalid", 32'(ins_valid), 32'h0);
        tick();
        check("rm_valid", 32'(ins_valid), 32'h1);
        check("rm_data",  32'(ins_data),  32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
